// File: rtl/isp_pkg.sv
// Shared fixed-point constants and FSM state type
// for the YCbCr 4:2:2 packing path.
package isp_pkg;
    localparam int PIX_W     = 18;
    localparam int FRAC_BITS = 9;
    localparam int Y_RND     = 1 << (FRAC_BITS - 1);
    localparam int C_RND     = 1 << FRAC_BITS;
    localparam int C_OFS     = 128;
    localparam int Q_MIN     = 0;
    localparam int Q_MAX     = 255;

    typedef enum logic {
        S_EVEN,
        S_ODD
    } state_t;
endpackage

// File: rtl/ycc422_pack_if.sv
// Pixel-in / packed-word-out bus of ycc422_pack.
// The bench drives through master, the block sits on slave.
interface ycc422_pack_if;
    import isp_pkg::*;

    logic                    iValid;
    logic signed [PIX_W-1:0] iY;
    logic signed [PIX_W-1:0] iCb;
    logic signed [PIX_W-1:0] iCr;
    logic [15:0]             oData;
    logic                    oValid;
    logic                    oDone;

    modport master (
        output iValid, iY, iCb, iCr,
        input  oData, oValid, oDone
    );

    modport slave (
        input  iValid, iY, iCb, iCr,
        output oData, oValid, oDone
    );
endinterface

// File: rtl/ycc_quant.sv
// Signed fixed-point to 8-bit unsigned: round, shift,
// offset and clamp. Used for luma and chroma averages.
module ycc_quant
    import isp_pkg::*;
#(
    parameter int IW    = 18,
    parameter int SHIFT = 9,
    parameter int RND   = 256,
    parameter int OFS   = 0
) (
    input  logic signed [IW-1:0] i_val,
    output logic [7:0]           o_q
);
    // Headroom so rounding and offset never wrap
    localparam int EW = IW + 3;

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_sh;
    logic signed [EW-1:0] w_ofs;

    assign w_ext = $signed({{3{i_val[IW-1]}}, i_val})
                 + EW'(RND);
    assign w_sh  = w_ext >>> SHIFT;
    assign w_ofs = w_sh + EW'(OFS);

    assign o_q = (w_ofs < EW'(Q_MIN)) ? 8'(Q_MIN) :
                 (w_ofs > EW'(Q_MAX)) ? 8'(Q_MAX) :
                 w_ofs[7:0];
endmodule

// File: rtl/ycc422_pack.sv
// Packs pixel pairs into 4:2:2 words {Y, Cb} then {Y, Cr},
// with a frame-done pulse on the last word of each frame.
module ycc422_pack
    import isp_pkg::*;
#(
    parameter int width     = 320,
    parameter int height    = 240,
    parameter int frameSize = width * height
) (
    input  logic          clk,
    input  logic          reset,
    ycc422_pack_if.slave  bus
);
    localparam int CW = (width > 1) ? $clog2(width) : 1;
    localparam int PW = (frameSize > 1) ? $clog2(frameSize) : 1;

    if ((width % 2) != 0) begin : g_width_chk
        $error("ycc422_pack: width must be even");
    end

    state_t                  r_state;
    logic signed [PIX_W-1:0] r_hy;
    logic signed [PIX_W-1:0] r_hcb;
    logic signed [PIX_W-1:0] r_hcr;
    logic [CW-1:0]           r_col;
    logic [PW-1:0]           r_pix;
    logic [15:0]             r_w1;
    logic                    r_w1_vld;
    logic                    r_w1_done;
    logic [15:0]             r_odata;
    logic                    r_ovalid;
    logic                    r_odone;

    logic signed [PIX_W:0]   w_sum_cb;
    logic signed [PIX_W:0]   w_sum_cr;
    logic [7:0]              w_qy_even;
    logic [7:0]              w_qy_odd;
    logic [7:0]              w_qcb;
    logic [7:0]              w_qcr;
    logic                    w_last_col;
    logic                    w_last_pix;

    // Sum of two 18-bit values always fits in 19 bits
    assign w_sum_cb = {r_hcb[PIX_W-1], r_hcb}
                    + {bus.iCb[PIX_W-1], bus.iCb};
    assign w_sum_cr = {r_hcr[PIX_W-1], r_hcr}
                    + {bus.iCr[PIX_W-1], bus.iCr};

    assign w_last_col = (r_col == CW'(width - 1));
    assign w_last_pix = (r_pix == PW'(frameSize - 1));

    ycc_quant #(
        .IW(PIX_W), .SHIFT(FRAC_BITS),
        .RND(Y_RND), .OFS(0)
    ) u_qy_even (.i_val(r_hy), .o_q(w_qy_even));

    ycc_quant #(
        .IW(PIX_W), .SHIFT(FRAC_BITS),
        .RND(Y_RND), .OFS(0)
    ) u_qy_odd (.i_val(bus.iY), .o_q(w_qy_odd));

    ycc_quant #(
        .IW(PIX_W + 1), .SHIFT(FRAC_BITS + 1),
        .RND(C_RND), .OFS(C_OFS)
    ) u_qcb (.i_val(w_sum_cb), .o_q(w_qcb));

    ycc_quant #(
        .IW(PIX_W + 1), .SHIFT(FRAC_BITS + 1),
        .RND(C_RND), .OFS(C_OFS)
    ) u_qcr (.i_val(w_sum_cr), .o_q(w_qcr));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_EVEN;
            r_hy      <= '0;
            r_hcb     <= '0;
            r_hcr     <= '0;
            r_col     <= '0;
            r_pix     <= '0;
            r_w1      <= '0;
            r_w1_vld  <= 1'b0;
            r_w1_done <= 1'b0;
            r_odata   <= '0;
            r_ovalid  <= 1'b0;
            r_odone   <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            r_odone  <= 1'b0;
            // An odd pixel can never land in the word1 cycle
            if (r_w1_vld) begin
                r_odata  <= r_w1;
                r_ovalid <= 1'b1;
                r_odone  <= r_w1_done;
                r_w1_vld <= 1'b0;
            end
            if (bus.iValid) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                r_pix <= w_last_pix ? '0 : r_pix + 1'b1;
                unique case (r_state)
                    S_EVEN: begin
                        r_hy    <= bus.iY;
                        r_hcb   <= bus.iCb;
                        r_hcr   <= bus.iCr;
                        r_state <= S_ODD;
                    end
                    S_ODD: begin
                        r_odata   <= {w_qy_even, w_qcb};
                        r_ovalid  <= 1'b1;
                        r_w1      <= {w_qy_odd, w_qcr};
                        r_w1_vld  <= 1'b1;
                        r_w1_done <= w_last_pix;
                        r_state   <= S_EVEN;
                    end
                    default: r_state <= S_EVEN;
                endcase
            end
        end
    end

    assign bus.oData  = r_odata;
    assign bus.oValid = r_ovalid;
    assign bus.oDone  = r_odone;
endmodule
